miner_nonce_scheduler: RTL

- Dispatches a contiguous nonce range across NUM_CORES parallel miner cores.
- Each core is started with a one-cycle hash_enable pulse and signals completion with a finished pulse.
- On the first qualifying hash the block stops dispatching, drains the in-flight cores and reports the winning nonce.
- Sits between the job/register front end and the array of miner_core instances.

---
 rtl/miner_nonce_scheduler.sv | 188 ++++++++++++++++++
 1 files changed

// File: rtl/miner_nonce_scheduler.sv
// Nonce range dispatcher for an array of miner cores.
module miner_nonce_scheduler #(
  parameter int NUM_CORES = 4,
  parameter int NONCE_W   = 32
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic                         abort,
  input  logic [NONCE_W-1:0]           nonce_base,
  input  logic [NONCE_W-1:0]           nonce_count,
  input  logic [NUM_CORES-1:0]         core_finished,
  input  logic [NUM_CORES-1:0]         core_hit,
  output logic [NUM_CORES-1:0]         core_enable,
  output logic [NUM_CORES*NONCE_W-1:0] core_nonce,
  output logic [NUM_CORES-1:0]         core_busy,
  output logic                         busy,
  output logic                         done,
  output logic                         found,
  output logic [NONCE_W-1:0]           found_nonce,
  output logic [NONCE_W-1:0]           hashes_done
);

  localparam int          PTR_W = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;
  localparam int unsigned NC_U  = NUM_CORES;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t                            state_q, state_d;
  logic [NONCE_W-1:0]                next_nonce_q, next_nonce_d;
  logic [NONCE_W-1:0]                remaining_q, remaining_d;
  logic [PTR_W-1:0]                  rr_ptr_q, rr_ptr_d;
  logic [NUM_CORES-1:0]              core_enable_q, core_enable_d;
  logic [NUM_CORES-1:0][NONCE_W-1:0] core_nonce_q, core_nonce_d;
  logic [NUM_CORES-1:0]              core_busy_q, core_busy_d;
  logic                              busy_q, busy_d;
  logic                              done_q, done_d;
  logic                              found_q, found_d;
  logic [NONCE_W-1:0]                found_nonce_q, found_nonce_d;
  logic [NONCE_W-1:0]                hashes_q, hashes_d;

  logic [NUM_CORES-1:0] fin_valid;
  logic [NUM_CORES-1:0] busy_after;
  logic [NUM_CORES-1:0] eligible;
  logic [NUM_CORES-1:0] hit_vec;
  logic                 stop_run;
  logic                 sel_valid;
  logic [PTR_W-1:0]     sel_idx;
  logic [PTR_W-1:0]     idx;
  logic                 hit_valid;
  logic [NONCE_W-1:0]   hit_nonce;
  logic [NONCE_W:0]     hash_sum;
  logic [NONCE_W-1:0]   hashes_sat;

  assign fin_valid  = core_finished & core_busy_q;
  assign busy_after = core_busy_q & ~core_finished;
  assign eligible   = ~core_busy_q & ~core_finished;
  assign hit_vec    = core_hit & fin_valid;
  assign stop_run   = (remaining_q == '0) || found_q || abort;

  // Round-robin pick, lowest-hit pick and saturating finish count
  always_comb begin
    sel_valid = 1'b0;
    sel_idx   = '0;
    idx       = '0;
    for (int unsigned j = 0; j < NC_U; j++) begin
      idx = PTR_W'((32'(rr_ptr_q) + j) % NC_U);
      if (!sel_valid && eligible[idx]) begin
        sel_valid = 1'b1;
        sel_idx   = idx;
      end
    end
    hit_valid = 1'b0;
    hit_nonce = '0;
    for (int unsigned j = 0; j < NC_U; j++) begin
      if (!hit_valid && hit_vec[j]) begin
        hit_valid = 1'b1;
        hit_nonce = core_nonce_q[j];
      end
    end
    hash_sum = {1'b0, hashes_q};
    for (int unsigned j = 0; j < NC_U; j++) begin
      hash_sum = hash_sum + {{NONCE_W{1'b0}}, fin_valid[j]};
    end
    hashes_sat = hash_sum[NONCE_W] ? '1 : hash_sum[NONCE_W-1:0];
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (stop_run) state_d = DRAIN;
      DRAIN:   if (busy_after == '0) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath and registered outputs
  always_comb begin
    next_nonce_d  = next_nonce_q;
    remaining_d   = remaining_q;
    rr_ptr_d      = rr_ptr_q;
    core_enable_d = '0;
    core_nonce_d  = core_nonce_q;
    core_busy_d   = busy_after;
    done_d        = 1'b0;
    found_d       = found_q;
    found_nonce_d = found_nonce_q;
    hashes_d      = hashes_sat;
    busy_d        = (state_d != IDLE);
    if (!found_q && hit_valid) begin
      found_d       = 1'b1;
      found_nonce_d = hit_nonce;
    end
    unique case (state_q)
      IDLE: begin
        if (start) begin
          next_nonce_d  = nonce_base;
          remaining_d   = nonce_count;
          rr_ptr_d      = '0;
          found_d       = 1'b0;
          found_nonce_d = '0;
          hashes_d      = '0;
        end
      end
      RUN: begin
        if (!stop_run && sel_valid) begin
          core_enable_d[sel_idx] = 1'b1;
          core_nonce_d[sel_idx]  = next_nonce_q;
          core_busy_d[sel_idx]   = 1'b1;
          next_nonce_d           = next_nonce_q + 1'b1;
          remaining_d            = remaining_q - 1'b1;
          rr_ptr_d = (sel_idx == PTR_W'(NUM_CORES - 1)) ? '0 : sel_idx + 1'b1;
        end
      end
      DRAIN: begin
        if (busy_after == '0) done_d = 1'b1;
      end
      default: ;
    endcase
  end

  // Datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      next_nonce_q  <= '0;
      remaining_q   <= '0;
      rr_ptr_q      <= '0;
      core_enable_q <= '0;
      core_nonce_q  <= '0;
      core_busy_q   <= '0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      found_q       <= 1'b0;
      found_nonce_q <= '0;
      hashes_q      <= '0;
    end else begin
      next_nonce_q  <= next_nonce_d;
      remaining_q   <= remaining_d;
      rr_ptr_q      <= rr_ptr_d;
      core_enable_q <= core_enable_d;
      core_nonce_q  <= core_nonce_d;
      core_busy_q   <= core_busy_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      found_q       <= found_d;
      found_nonce_q <= found_nonce_d;
      hashes_q      <= hashes_d;
    end
  end

  assign core_enable = core_enable_q;
  assign core_nonce  = core_nonce_q;
  assign core_busy   = core_busy_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign found       = found_q;
  assign found_nonce = found_nonce_q;
  assign hashes_done = hashes_q;

endmodule
